// File: rtl/lector_pkg.sv
// Shared constants and state encoding for the output-FIFO reader.
package lector_pkg;
    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    localparam int DATA_W_DEF = 10;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;
endpackage

// File: rtl/lector_fifos_salida_if.sv
// FIFO-bank, sink and counter-readback signals of the reader; master = reader side.
interface lector_fifos_salida_if #(
    parameter int data_width = 10,
    parameter int cnt_width  = 5
);
    import lector_pkg::*;

    logic                  empty4, empty5, empty6, empty7;
    logic [data_width-1:0] FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7;
    logic                  pop4, pop5, pop6, pop7;
    logic [data_width-1:0] data_out;
    logic [CH_W-1:0]       src_out;
    logic                  valid_out;
    logic                  sink_ready;
    logic                  req;
    logic [CH_W-1:0]       idx;
    logic [cnt_width-1:0]  contador_out;
    logic                  valid_contador;

    modport master (
        input  empty4, empty5, empty6, empty7,
        input  FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7,
        output pop4, pop5, pop6, pop7,
        output data_out, src_out, valid_out,
        input  sink_ready, req, idx,
        output contador_out, valid_contador
    );

    modport slave (
        output empty4, empty5, empty6, empty7,
        output FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7,
        input  pop4, pop5, pop6, pop7,
        input  data_out, src_out, valid_out,
        output sink_ready, req, idx,
        input  contador_out, valid_contador
    );
endinterface

// File: rtl/lector_arbitro.sv
// Picks one non-empty FIFO per cycle. ARB_RR_EN selects round-robin, else fixed
// priority with FIFO4 highest.
module lector_arbitro
    import lector_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_empty,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_pop,
    output logic [CH_W-1:0]   o_gnt
);
    logic            w_found;
    logic [CH_W-1:0] w_gnt;

`ifdef ARB_RR_EN
    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_c;

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_c     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_c = r_ptr + CH_W'(k);
            if (!w_found && !i_empty[w_c]) begin
                w_found = 1'b1;
                w_gnt   = w_c;
            end
        end
    end

    // Pointer lands on the FIFO after the one just granted.
    always_ff @(posedge clk) begin
        if (reset)       r_ptr <= '0;
        else if (|o_pop) r_ptr <= w_gnt + CH_W'(1);
    end
`else
    logic w_unused;
    assign w_unused = clk ^ reset;

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!i_empty[k]) begin
                w_found = 1'b1;
                w_gnt   = CH_W'(k);
            end
        end
    end
`endif

    assign o_pop = (i_en && w_found) ? (NUM_CH'(1) << w_gnt) : '0;
    assign o_gnt = w_gnt;
endmodule

// File: rtl/lector_fifos_salida.sv
// Output FIFO bank reader: pops FIFOs 4..7 into a 2-entry buffer, keeps saturating
// per-FIFO word counts. Arbitration mode set by ARB_RR_EN (see lector_arbitro).
module lector_fifos_salida
    import lector_pkg::*;
#(
    parameter int data_width = DATA_W_DEF,
    parameter int cnt_width  = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    output logic                 IDLE,
    lector_fifos_salida_if.master bus
);
    state_t                               r_state, w_next;
    logic                                 w_active, w_grant_en, w_deq;
    logic [2:0]                           w_load;
    logic [NUM_CH-1:0]                    w_empty, w_pop;
    logic [CH_W-1:0]                      w_gnt;
    logic [NUM_CH-1:0][data_width-1:0]    w_fdata;
    logic [data_width-1:0]                w_new;
    logic                                 r_inflight;
    logic [CH_W-1:0]                      r_src_fl;
    logic [1:0]                           r_occ;
    logic [1:0][data_width-1:0]           r_bdata;
    logic [1:0][CH_W-1:0]                 r_bsrc;
    logic [NUM_CH-1:0][cnt_width-1:0]     r_cnt;
    logic                                 r_vcnt;
    logic [cnt_width-1:0]                 r_cnt_out;

    assign w_empty = {bus.empty7, bus.empty6, bus.empty5, bus.empty4};
    assign w_fdata = {bus.FIFO_data_out7, bus.FIFO_data_out6, bus.FIFO_data_out5, bus.FIFO_data_out4};
    assign {bus.pop7, bus.pop6, bus.pop5, bus.pop4} = w_pop;
    assign w_new   = w_fdata[r_src_fl];

    // Slots committed after this cycle's dequeue; a pop may only target a free one.
    assign w_deq      = bus.valid_out & bus.sink_ready;
    assign w_load     = 3'(r_occ) + 3'(r_inflight) - 3'(w_deq);
    assign w_grant_en = w_active & ~reset & ~init & (w_load < 3'd2);

    lector_arbitro u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_empty (w_empty),
        .i_en    (w_grant_en),
        .o_pop   (w_pop),
        .o_gnt   (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RESET;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (init) w_next = ST_INIT;
        else begin
            case (r_state)
                ST_RESET:  w_next = ST_INIT;
                ST_INIT:   w_next = ST_IDLE;
                ST_IDLE:   if (!(&w_empty)) w_next = ST_ACTIVE;
                ST_ACTIVE: if ((&w_empty) && !r_inflight && r_occ == 2'd0) w_next = ST_IDLE;
                default:   w_next = ST_RESET;
            endcase
        end
    end

    always_comb begin
        IDLE     = (r_state == ST_IDLE);
        w_active = (r_state == ST_ACTIVE);
    end

    // Reset or init also drops a word still in flight from an earlier pop.
    always_ff @(posedge clk) begin
        if (reset || init) begin
            r_inflight <= 1'b0;
            r_src_fl   <= '0;
            r_occ      <= 2'd0;
            r_bdata    <= '0;
            r_bsrc     <= '0;
            r_cnt      <= '0;
        end else begin
            r_inflight <= |w_pop;
            if (|w_pop) r_src_fl <= w_gnt;
            if (r_inflight && r_cnt[r_src_fl] != '1)
                r_cnt[r_src_fl] <= r_cnt[r_src_fl] + cnt_width'(1);
            case ({r_inflight, w_deq})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_bdata[0] <= w_new;
                        r_bsrc[0]  <= r_src_fl;
                    end else begin
                        r_bdata[1] <= w_new;
                        r_bsrc[1]  <= r_src_fl;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_bdata[0] <= r_bdata[1];
                    r_bsrc[0]  <= r_bsrc[1];
                    r_occ      <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_bdata[0] <= w_new;
                        r_bsrc[0]  <= r_src_fl;
                    end else begin
                        r_bdata[0] <= r_bdata[1];
                        r_bsrc[0]  <= r_bsrc[1];
                        r_bdata[1] <= w_new;
                        r_bsrc[1]  <= r_src_fl;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vcnt    <= 1'b0;
            r_cnt_out <= '0;
        end else if (bus.req && r_state != ST_RESET && r_state != ST_INIT) begin
            r_vcnt    <= 1'b1;
            r_cnt_out <= r_cnt[bus.idx];
        end else begin
            r_vcnt    <= 1'b0;
        end
    end

    assign bus.data_out       = r_bdata[0];
    assign bus.src_out        = r_bsrc[0];
    assign bus.valid_out      = (r_occ != 2'd0);
    assign bus.contador_out   = r_cnt_out;
    assign bus.valid_contador = r_vcnt;
endmodule

// File: tb/tb_lector_fifos_salida.sv
// Directed bench for lector_fifos_salida with a behavioural model of FIFOs 4..7.
module tb_lector_fifos_salida;
    import lector_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init = 1'b1;
    logic IDLE;

    lector_fifos_salida_if #(.data_width(10), .cnt_width(5)) bus();

    lector_fifos_salida #(.data_width(10), .cnt_width(5)) dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .IDLE  (IDLE),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int evals = 0;
    int fails = 0;
    int cyc   = 0;
    int multi = 0;

    logic [9:0] fq [4][$];
    int         rd_ptr [4] = '{default: 0};
    logic [3:0] fempty = 4'hF;
    logic [3:0] pend = 4'h0;
    logic [9:0] fdata [4] = '{default: 10'h0};
    logic [3:0] w_pops;

    logic [9:0] out_data[$];
    logic [1:0] out_src[$];
    int         out_cyc[$];
    int         pop_ch[$];
    int         pop_cyc[$];

    assign bus.empty4 = fempty[0];
    assign bus.empty5 = fempty[1];
    assign bus.empty6 = fempty[2];
    assign bus.empty7 = fempty[3];
    assign bus.FIFO_data_out4 = fdata[0];
    assign bus.FIFO_data_out5 = fdata[1];
    assign bus.FIFO_data_out6 = fdata[2];
    assign bus.FIFO_data_out7 = fdata[3];
    assign w_pops = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};

    // FIFO model: read data valid the cycle after the pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int n = 0; n < 4; n++) begin
            if (pend[n] && rd_ptr[n] < fq[n].size()) begin
                fdata[n]  <= fq[n][rd_ptr[n]];
                rd_ptr[n] <= rd_ptr[n] + 1;
                fempty[n] <= (rd_ptr[n] + 1 >= fq[n].size());
            end else begin
                fempty[n] <= (rd_ptr[n] >= fq[n].size());
            end
        end
    end

    always @(negedge clk) begin
        pend <= w_pops;
        if ($countones(w_pops) > 1) multi <= multi + 1;
        for (int n = 0; n < 4; n++)
            if (w_pops[n]) begin
                pop_ch.push_back(n);
                pop_cyc.push_back(cyc);
            end
        if (bus.valid_out && bus.sink_ready) begin
            out_data.push_back(bus.data_out);
            out_src.push_back(bus.src_out);
            out_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; init = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int p0;
        reset = 1'b1; init = 1'b1;
        bus.sink_ready = 1'b1; bus.req = 1'b0; bus.idx = 2'd0;
        tick(); tick();
        evals++;
        if ({IDLE, bus.valid_out, bus.valid_contador, w_pops} !== 7'd0) begin
            fails++; $display("FAIL reset_flags: got %b expected 0000000", {IDLE, bus.valid_out, bus.valid_contador, w_pops});
        end
        evals++;
        if (bus.data_out !== 10'd0 || bus.src_out !== 2'd0) begin
            fails++; $display("FAIL reset_data: got %h/%0d expected 000/0", bus.data_out, bus.src_out);
        end
        evals++;
        if (bus.contador_out !== 5'd0) begin
            fails++; $display("FAIL reset_contador: got %0d expected 0", bus.contador_out);
        end
        reset = 1'b0;
        tick();
        evals++;
        if (IDLE !== 1'b0) begin fails++; $display("FAIL init_IDLE: got %b expected 0", IDLE); end
        init = 1'b0;
        tick();
        evals++;
        if (IDLE !== 1'b1) begin fails++; $display("FAIL idle_entry: got %b expected 1", IDLE); end
        p0 = pop_ch.size();
        repeat (3) tick();
        evals++;
        if (pop_ch.size() !== p0 || bus.valid_out !== 1'b0) begin
            fails++; $display("FAIL idle_quiet: pops %0d valid %b expected 0 pops valid 0", pop_ch.size() - p0, bus.valid_out);
        end
    endtask

    task automatic test_single();
        int p0, o0;
        p0 = pop_ch.size(); o0 = out_data.size();
        fq[1].push_back(10'h155);
        for (int i = 0; i < 30 && out_data.size() < o0 + 1; i++) tick();
        evals++;
        if (out_data.size() !== o0 + 1) begin
            fails++; $display("FAIL single_timeout: got %0d words expected 1", out_data.size() - o0);
        end else begin
            evals++;
            if (out_data[o0] !== 10'h155 || out_src[o0] !== 2'd1) begin
                fails++; $display("FAIL single_word: got %h/%0d expected 155/1", out_data[o0], out_src[o0]);
            end
            evals++;
            if (pop_ch.size() !== p0 + 1 || pop_ch[p0] !== 1) begin
                fails++; $display("FAIL single_pop: got %0d pops expected one pop5", pop_ch.size() - p0);
            end else begin
                evals++;
                if (out_cyc[o0] - pop_cyc[p0] !== 2) begin
                    fails++; $display("FAIL single_latency: got %0d expected 2", out_cyc[o0] - pop_cyc[p0]);
                end
            end
        end
        bus.req = 1'b1; bus.idx = 2'd1;
        tick();
        bus.req = 1'b0;
        evals++;
        if (bus.valid_contador !== 1'b1 || bus.contador_out !== 5'd1) begin
            fails++; $display("FAIL single_count: got %b/%0d expected 1/1", bus.valid_contador, bus.contador_out);
        end
        tick();
        evals++;
        if (bus.valid_contador !== 1'b0 || bus.contador_out !== 5'd1) begin
            fails++; $display("FAIL count_hold: got %b/%0d expected 0/1", bus.valid_contador, bus.contador_out);
        end
    endtask

    task automatic test_arbitration();
        int o0, ech, ek;
        do_reset();
        o0 = out_data.size();
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k < 3; k++) fq[ch].push_back(10'(ch * 64 + k + 5));
        for (int i = 0; i < 60 && out_data.size() < o0 + 12; i++) tick();
        evals++;
        if (out_data.size() !== o0 + 12) begin
            fails++; $display("FAIL arb_timeout: got %0d words expected 12", out_data.size() - o0);
        end else begin
            for (int i = 0; i < 12; i++) begin
`ifdef ARB_RR_EN
                ech = i % 4; ek = i / 4;
`else
                ech = i / 3; ek = i % 3;
`endif
                evals++;
                if (out_src[o0 + i] !== 2'(ech) || out_data[o0 + i] !== 10'(ech * 64 + ek + 5)) begin
                    fails++; $display("FAIL arb_order[%0d]: got %h/%0d expected %h/%0d", i,
                                      out_data[o0 + i], out_src[o0 + i], 10'(ech * 64 + ek + 5), ech);
                end
            end
            evals++;
            if (out_cyc[o0 + 11] - out_cyc[o0] !== 11) begin
                fails++; $display("FAIL arb_throughput: got %0d cycles expected 11", out_cyc[o0 + 11] - out_cyc[o0]);
            end
        end
        evals++;
        if (multi !== 0) begin fails++; $display("FAIL onehot: got %0d multi-pop cycles expected 0", multi); end
        bus.req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            bus.idx = 2'(n);
            tick();
            evals++;
            if (bus.valid_contador !== 1'b1 || bus.contador_out !== 5'd3) begin
                fails++; $display("FAIL arb_count[%0d]: got %b/%0d expected 1/3", n, bus.valid_contador, bus.contador_out);
            end
        end
        bus.req = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int p0, o0;
        logic stable;
        bus.sink_ready = 1'b0;
        p0 = pop_ch.size(); o0 = out_data.size();
        for (int k = 0; k < 5; k++) fq[2].push_back(10'h3C0 + 10'(k));
        repeat (12) tick();
        evals++;
        if (pop_ch.size() - p0 !== 2) begin
            fails++; $display("FAIL bp_pops: got %0d expected 2", pop_ch.size() - p0);
        end
        evals++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 10'h3C0 || bus.src_out !== 2'd2) begin
            fails++; $display("FAIL bp_head: got %b/%h/%0d expected 1/3c0/2", bus.valid_out, bus.data_out, bus.src_out);
        end
        stable = 1'b1;
        repeat (3) begin
            tick();
            if (bus.data_out !== 10'h3C0 || bus.valid_out !== 1'b1) stable = 1'b0;
        end
        evals++;
        if (stable !== 1'b1 || pop_ch.size() - p0 !== 2) begin
            fails++; $display("FAIL bp_stable: data %h pops %0d expected 3c0 and 2", bus.data_out, pop_ch.size() - p0);
        end
        bus.sink_ready = 1'b1;
        for (int i = 0; i < 40 && out_data.size() < o0 + 5; i++) tick();
        evals++;
        if (out_data.size() !== o0 + 5) begin
            fails++; $display("FAIL bp_timeout: got %0d words expected 5", out_data.size() - o0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                evals++;
                if (out_data[o0 + i] !== 10'h3C0 + 10'(i) || out_src[o0 + i] !== 2'd2) begin
                    fails++; $display("FAIL bp_drain[%0d]: got %h/%0d expected %h/2", i, out_data[o0 + i], out_src[o0 + i], 10'h3C0 + 10'(i));
                end
            end
        end
    endtask

    task automatic test_saturation();
        int o0;
        o0 = out_data.size();
        for (int i = 0; i < 40; i++) fq[3].push_back(10'(i));
        for (int i = 0; i < 150 && out_data.size() < o0 + 40; i++) tick();
        evals++;
        if (out_data.size() !== o0 + 40) begin
            fails++; $display("FAIL sat_timeout: got %0d words expected 40", out_data.size() - o0);
        end
        bus.req = 1'b1; bus.idx = 2'd3;
        tick();
        evals++;
        if (bus.valid_contador !== 1'b1 || bus.contador_out !== 5'd31) begin
            fails++; $display("FAIL sat_count: got %b/%0d expected 1/31", bus.valid_contador, bus.contador_out);
        end
        bus.idx = 2'd2;
        tick();
        bus.req = 1'b0;
        evals++;
        if (bus.contador_out !== 5'd8) begin
            fails++; $display("FAIL fifo6_count: got %0d expected 8", bus.contador_out);
        end
        init = 1'b1;
        tick();
        init = 1'b0; bus.req = 1'b1; bus.idx = 2'd3;
        tick();
        evals++;
        if (bus.valid_contador !== 1'b0) begin
            fails++; $display("FAIL req_in_init: got %b expected 0", bus.valid_contador);
        end
        tick();
        bus.req = 1'b0;
        evals++;
        if (bus.valid_contador !== 1'b1 || bus.contador_out !== 5'd0) begin
            fails++; $display("FAIL init_clear: got %b/%0d expected 1/0", bus.valid_contador, bus.contador_out);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        int o0;
        logic seen;
        o0 = out_data.size();
        seen = 1'b0;
        fq[0].push_back(10'h2AA);
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.pop4 === 1'b1) seen = 1'b1;
        end
        evals++;
        if (seen !== 1'b1) begin fails++; $display("FAIL inflight_pop: got no pop4 expected one"); end
        tick();
        reset = 1'b1;
        tick();
        evals++;
        if ({IDLE, bus.valid_out, bus.valid_contador, w_pops} !== 7'd0 || bus.data_out !== 10'd0 ||
            bus.src_out !== 2'd0 || bus.contador_out !== 5'd0) begin
            fails++; $display("FAIL inflight_reset: flags %b data %h src %0d cnt %0d expected all 0",
                              {IDLE, bus.valid_out, bus.valid_contador, w_pops}, bus.data_out, bus.src_out, bus.contador_out);
        end
        reset = 1'b0; init = 1'b1;
        tick();
        init = 1'b0;
        repeat (6) tick();
        evals++;
        if (out_data.size() !== o0 || IDLE !== 1'b1) begin
            fails++; $display("FAIL inflight_drop: got %0d words IDLE %b expected 0 words IDLE 1", out_data.size() - o0, IDLE);
        end
    endtask

    initial begin
        bus.sink_ready = 1'b1;
        bus.req = 1'b0;
        bus.idx = 2'd0;
        test_reset();
        test_single();
        test_arbitration();
        test_backpressure();
        test_saturation();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end
endmodule
